// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through byte buffer with occupancy count; a push into a
// full buffer is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign count    = count_q;
  assign rdata    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a FWFT byte buffer.
//   state     | meaning
//   IDLE      | line high, counters held at 0, waiting for falling edge
//   START     | qualifying start bit at mid-bit
//   DATA      | sampling 8 data bits LSB first
//   STOP      | sampling stop bit; push byte or flag framing error
//   WAIT_HIGH | after framing error, wait for line to return high
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          uart_txd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_fifo: clock divider below 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic [1:0]    sync_q;
  logic          line;
  rx_state_t     state_q, state_d;
  logic [DW-1:0] div_q;
  logic [3:0]    tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          tick;
  logic          mid_start;
  logic          bit_end;
  logic          push;
  logic          ferr_d;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic          frame_err_q;
  logic          overrun_q;

  assign line      = sync_q[1];
  assign tick      = (div_q == DW'(DIV - 1));
  assign mid_start = tick && (tick_q == 4'(MID_TICK));
  assign bit_end   = tick && (tick_q == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], uart_txd};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE:      if (!line) state_d = START;
      START:     if (mid_start) state_d = line ? IDLE : DATA;
      DATA:      if (bit_end && bit_q == 3'd7) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (line) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: if (line) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Mid-start restarts the tick count so each later sample lands 16 ticks on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else if (state_q == IDLE) begin
      div_q  <= '0;
      tick_q <= '0;
      bit_q  <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + DW'(1);
      if (tick) begin
        if (state_q == START && mid_start) tick_q <= '0;
        else                               tick_q <= tick_q + 4'd1;
      end
      if (state_q == DATA && bit_end) begin
        shreg_q <= {line, shreg_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .wdata    (shreg_q),
    .pop      (rx_ready),
    .rdata    (rx_data),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_d;
      overrun_q   <= fifo_ovf;
    end
  end

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
